// File: rtl/mem_test_sequencer.sv
// mem_test_sequencer
// Sequences a memory test: takes test parameters from the CSR block and
// issues write/read commands to the transmitter over a valid/ready
// handshake, steering the external address generator with next/rewind
// strobes. Supports repeated passes, abort, stop/continue on error and
// error/pass counters.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   test_start_i / test_abort_i  start pulse (IDLE only) / abort request
//   test_mode_i                  0 WR-only, 1 RD-only, 2 WR+check, 3 WR-then-RD
//   test_count_i, test_repeat_i  transactions per pass, passes (0 means 1)
//   stop_on_err_i                first compare error ends the test
//   cmp_error_i                  compare mismatch pulse
//   cmp_busy_i, meas_busy_i, trans_busy_i  downstream busy, gate completion
//   trans_ready_i / trans_valid_o, trans_type_o, trans_addr_o  command channel
//   addr_i                       current address from the address generator
//   addr_next_o / addr_rewind_o  advance / reload the address generator
//   test_busy_o, test_finished_o, test_result_o, test_aborted_o  status
//   err_cnt_o, pass_cnt_o        saturating error count, completed passes
module mem_test_sequencer #(
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REP_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic              test_abort_i,
  input  logic [2:0]        test_mode_i,
  input  logic [CNT_W-1:0]  test_count_i,
  input  logic [REP_W-1:0]  test_repeat_i,
  input  logic              stop_on_err_i,
  input  logic              cmp_error_i,
  input  logic              cmp_busy_i,
  input  logic              meas_busy_i,
  input  logic              trans_busy_i,
  input  logic              trans_ready_i,
  output logic              trans_valid_o,
  output logic              trans_type_o,
  output logic [ADDR_W-1:0] trans_addr_o,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              addr_next_o,
  output logic              addr_rewind_o,
  output logic              test_busy_o,
  output logic              test_finished_o,
  output logic              test_result_o,
  output logic              test_aborted_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [REP_W-1:0]  pass_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR_PASS,
    S_RD_PASS,
    S_WR_WORD,
    S_RD_WORD,
    S_REWIND,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             r_after_rewind;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_remaining;
  logic [REP_W-1:0]   r_repeat;
  logic [REP_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_finished;
  logic               r_result;
  logic               r_aborted;

  state_t             w_next;
  state_t             w_after_rewind;
  logic               w_issue;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_err;
  logic               w_abort;
  logic               w_force_drain;
  logic               w_dec;
  logic               w_addr_next;
  logic               w_pass_end;
  logic               w_more_passes;

  function automatic state_t first_state(input logic [1:0] mode);
    case (mode)
      2'd1:    return S_RD_PASS;
      2'd2:    return S_WR_WORD;
      default: return S_WR_PASS;
    endcase
  endfunction

  assign w_issue  = (r_state == S_WR_PASS) || (r_state == S_RD_PASS) ||
                    (r_state == S_WR_WORD) || (r_state == S_RD_WORD);
  assign w_accept = w_issue && trans_ready_i;
  assign w_last   = (r_remaining == CNT_W'(1));
  assign w_busy   = (r_state != S_IDLE);
  assign w_err    = w_busy && cmp_error_i;
  assign w_abort  = w_busy && (r_state != S_DRAIN) && test_abort_i;
  // Passes are counted up from zero and repeat is at least 1, so equality
  // marks the final pass without any wrap concern.
  assign w_more_passes = ((r_pass_cnt + REP_W'(1)) != r_repeat);
  // Abort or a stopping error wins over whatever the issue states decided,
  // including a same-cycle accept; an unaccepted command is simply dropped.
  assign w_force_drain = w_abort ||
                         (w_err && stop_on_err_i && (r_state != S_DRAIN));

  always_comb begin
    w_next         = r_state;
    w_after_rewind = r_after_rewind;
    w_dec          = 1'b0;
    w_addr_next    = 1'b0;
    w_pass_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (test_start_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        if ((test_count_i == '0) || test_mode_i[2]) w_next = S_DRAIN;
        else                                        w_next = first_state(test_mode_i[1:0]);
      end
      S_WR_PASS: begin
        if (w_accept) begin
          w_addr_next = 1'b1;
          w_dec       = 1'b1;
          if (w_last) begin
            if (r_mode == 2'd3) begin
              // Write half of a write-then-read pass: the pass is only
              // complete after the read-back half.
              w_next         = S_REWIND;
              w_after_rewind = S_RD_PASS;
            end else begin
              w_pass_end = 1'b1;
            end
          end
        end
      end
      S_RD_PASS: begin
        if (w_accept) begin
          w_addr_next = 1'b1;
          w_dec       = 1'b1;
          if (w_last) w_pass_end = 1'b1;
        end
      end
      S_WR_WORD: begin
        if (w_accept) w_next = S_RD_WORD;
      end
      S_RD_WORD: begin
        if (w_accept) begin
          w_addr_next = 1'b1;
          w_dec       = 1'b1;
          if (w_last) w_pass_end = 1'b1;
          else        w_next     = S_WR_WORD;
        end
      end
      S_REWIND: begin
        w_next = r_after_rewind;
      end
      S_DRAIN: begin
        if (!cmp_busy_i && !meas_busy_i && !trans_busy_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    if (w_pass_end) begin
      if (w_more_passes) begin
        w_next         = S_REWIND;
        w_after_rewind = first_state(r_mode);
      end else begin
        w_next = S_DRAIN;
      end
    end

    if (w_force_drain) w_next = S_DRAIN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_after_rewind <= S_WR_PASS;
      r_mode         <= '0;
      r_count        <= '0;
      r_remaining    <= '0;
      r_repeat       <= '0;
      r_pass_cnt     <= '0;
      r_err_cnt      <= '0;
      r_finished     <= 1'b0;
      r_result       <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_after_rewind <= w_after_rewind;

      if ((r_state == S_IDLE) && test_start_i) begin
        r_finished <= 1'b0;
        r_result   <= 1'b0;
        r_aborted  <= 1'b0;
        r_err_cnt  <= '0;
        r_pass_cnt <= '0;
      end

      if (r_state == S_LOAD) begin
        r_mode      <= test_mode_i[1:0];
        r_count     <= test_count_i;
        r_remaining <= test_count_i;
        r_repeat    <= (test_repeat_i == '0) ? REP_W'(1) : test_repeat_i;
        if (test_mode_i[2]) r_result <= 1'b1;
      end

      if (r_state == S_REWIND) r_remaining <= r_count;
      if (w_dec)               r_remaining <= r_remaining - CNT_W'(1);
      if (w_pass_end)          r_pass_cnt  <= r_pass_cnt + REP_W'(1);

      if (w_err) begin
        r_result <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end

      if (w_abort) r_aborted <= 1'b1;

      if ((r_state == S_DRAIN) && (w_next == S_IDLE)) r_finished <= 1'b1;
    end
  end

  assign trans_valid_o   = w_issue;
  assign trans_type_o    = (r_state == S_RD_PASS) || (r_state == S_RD_WORD);
  assign trans_addr_o    = w_issue ? addr_i : '0;
  assign addr_next_o     = w_addr_next;
  assign addr_rewind_o   = (r_state == S_LOAD) || (r_state == S_REWIND);
  assign test_busy_o     = w_busy;
  assign test_finished_o = r_finished;
  assign test_result_o   = r_result;
  assign test_aborted_o  = r_aborted;
  assign err_cnt_o       = r_err_cnt;
  assign pass_cnt_o      = r_pass_cnt;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// tb_mem_test_sequencer
// Scoreboard bench for mem_test_sequencer. Each test builds the expected
// command stream from the test parameters (plain loops over passes and
// words), queues it, and a monitor pops and compares every accepted
// command. An injector raises compare errors / aborts on chosen accepts
// and models downstream busy tails; a small address generator model
// answers the next/rewind strobes.
module tb_mem_test_sequencer;
  localparam int ADDR_W = 31;
  localparam int CNT_W  = 4;
  localparam int REP_W  = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_i;
  logic              test_start_i, test_abort_i;
  logic [2:0]        test_mode_i;
  logic [CNT_W-1:0]  test_count_i;
  logic [REP_W-1:0]  test_repeat_i;
  logic              stop_on_err_i, cmp_error_i;
  logic              cmp_busy_i, meas_busy_i, trans_busy_i, trans_ready_i;
  logic              trans_valid_o, trans_type_o;
  logic [ADDR_W-1:0] trans_addr_o, addr_i;
  logic              addr_next_o, addr_rewind_o;
  logic              test_busy_o, test_finished_o, test_result_o, test_aborted_o;
  logic [CNT_W-1:0]  err_cnt_o;
  logic [REP_W-1:0]  pass_cnt_o;

  mem_test_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .test_start_i(test_start_i), .test_abort_i(test_abort_i),
    .test_mode_i(test_mode_i), .test_count_i(test_count_i),
    .test_repeat_i(test_repeat_i), .stop_on_err_i(stop_on_err_i),
    .cmp_error_i(cmp_error_i), .cmp_busy_i(cmp_busy_i),
    .meas_busy_i(meas_busy_i), .trans_busy_i(trans_busy_i),
    .trans_ready_i(trans_ready_i), .trans_valid_o(trans_valid_o),
    .trans_type_o(trans_type_o), .trans_addr_o(trans_addr_o),
    .addr_i(addr_i), .addr_next_o(addr_next_o), .addr_rewind_o(addr_rewind_o),
    .test_busy_o(test_busy_o), .test_finished_o(test_finished_o),
    .test_result_o(test_result_o), .test_aborted_o(test_aborted_o),
    .err_cnt_o(err_cnt_o), .pass_cnt_o(pass_cnt_o)
  );

  typedef struct packed {
    logic              typ;
    logic              adv;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t              exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                cyc = 0;
  logic [ADDR_W-1:0] base = '0;
  int                rmode = 0;
  bit                sb_off = 0;
  int                n_next = 0, n_rew = 0;
  bit                seen_valid = 0;
  int                first_valid_cyc = 0;
  logic [63:0]       err_mask = '0;
  bit                stop_cfg = 0;
  int                abort_at = 0, inj_acc = 0, inj_rd = 0;
  int                cb_left = 0, tb_left = 0, mb_left = 0;
  bit                chk_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Address generator: reload on rewind, increment on next.
  always @(posedge clk) begin
    if (rst_i)              addr_i <= '0;
    else if (addr_rewind_o) addr_i <= base;
    else if (addr_next_o)   addr_i <= addr_i + ADDR_W'(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic typ, input logic adv, input logic [ADDR_W-1:0] a);
    cmd_t c;
    c.typ = typ; c.adv = adv; c.addr = a;
    return c;
  endfunction

  // Ready pattern generator
  initial begin
    trans_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       trans_ready_i = 1'b1;
        1:       trans_ready_i = ~trans_ready_i;
        default: trans_ready_i = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, strobe counting
  initial begin
    bit                stalled;
    logic              st_type;
    logic [ADDR_W-1:0] st_addr;
    cmd_t              e;
    stalled = 0; st_type = 0; st_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_i || sb_off) begin
        stalled = 0;
      end else begin
        if (addr_next_o)   n_next++;
        if (addr_rewind_o) n_rew++;
        if (trans_valid_o && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (stalled && trans_valid_o) begin
          check("stall_type", trans_type_o, st_type);
          check("stall_addr", trans_addr_o, st_addr);
        end
        stalled = trans_valid_o && !trans_ready_i;
        st_type = trans_type_o;
        st_addr = trans_addr_o;
        if (trans_valid_o && trans_ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_extra: got type %0d addr %0h, expected no command", trans_type_o, trans_addr_o);
          end else begin
            e = exp_q.pop_front();
            check("cmd_type", trans_type_o, e.typ);
            check("cmd_addr", trans_addr_o, e.addr);
          end
        end
      end
    end
  end

  // Injector: errors on chosen reads, abort on a chosen accept, busy tails
  initial begin
    cmp_error_i = 0; test_abort_i = 0;
    cmp_busy_i = 0; meas_busy_i = 0; trans_busy_i = 0;
    forever begin
      @(negedge clk);
      cmp_error_i  = 0;
      test_abort_i = 0;
      if (chk_drop) begin
        chk_drop = 0;
        check("valid_drop", trans_valid_o, 0);
      end
      if (!rst_i && trans_valid_o && trans_ready_i) begin
        inj_acc++;
        if (trans_type_o) begin
          if (inj_rd < 64 && err_mask[inj_rd]) begin
            cmp_error_i = 1;
            if (stop_cfg) begin chk_drop = 1; cb_left = 5; end
          end
          inj_rd++;
        end
        if (inj_acc == abort_at) begin
          test_abort_i = 1; chk_drop = 1; tb_left = 5;
        end
      end
      cmp_busy_i   = (cb_left > 0); if (cb_left > 0) cb_left--;
      trans_busy_i = (tb_left > 0); if (tb_left > 0) tb_left--;
      meas_busy_i  = (mb_left > 0); if (mb_left > 0) mb_left--;
    end
  end

  task automatic do_reset();
    rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
  endtask

  task automatic run_test(input int mode, input int cnt, input int rep, input bit stop,
                          input logic [63:0] mask, input int abrt, input int pre_busy,
                          input int rm, input bit mid_start);
    cmd_t full[$];
    int eff, n_ok, errs, rd, exp_next, exp_rew, waited, start_cyc, finish_cyc;
    bit ev, exp_ab, viol;
    logic [ADDR_W-1:0] b;
    @(posedge clk); #1;
    b = ADDR_W'($urandom);
    base = b;
    eff = (rep == 0) ? 1 : rep;
    if (mode <= 3 && cnt > 0) begin
      for (int p = 0; p < eff; p++) begin
        if (mode == 3) begin
          for (int i = 0; i < cnt; i++) full.push_back(mk(1'b0, 1'b1, b + ADDR_W'(i)));
          for (int i = 0; i < cnt; i++) full.push_back(mk(1'b1, 1'b1, b + ADDR_W'(i)));
        end else begin
          for (int i = 0; i < cnt; i++) begin
            if (mode == 0) full.push_back(mk(1'b0, 1'b1, b + ADDR_W'(i)));
            if (mode == 1) full.push_back(mk(1'b1, 1'b1, b + ADDR_W'(i)));
            if (mode == 2) begin
              full.push_back(mk(1'b0, 1'b0, b + ADDR_W'(i)));
              full.push_back(mk(1'b1, 1'b1, b + ADDR_W'(i)));
            end
          end
        end
      end
    end
    n_ok = full.size(); errs = 0; rd = 0; ev = 0; exp_ab = 0;
    for (int k = 0; k < full.size(); k++) begin
      if (full[k].typ) begin
        if (rd < 64 && mask[rd]) begin
          errs++;
          if (stop) begin n_ok = k + 1; ev = 1; end
        end
        rd++;
      end
      if (abrt == k + 1) begin n_ok = k + 1; ev = 1; exp_ab = 1; end
      if (ev) break;
    end
    exp_next = 0;
    for (int k = 0; k < n_ok; k++) begin
      exp_q.push_back(full[k]);
      if (full[k].adv) exp_next++;
    end
    exp_rew = (mode > 3 || cnt == 0) ? 1 : ((mode == 3) ? 2 * eff : eff);

    test_mode_i = 3'(mode); test_count_i = CNT_W'(cnt); test_repeat_i = REP_W'(rep);
    stop_on_err_i = stop;
    err_mask = mask; stop_cfg = stop; abort_at = abrt; inj_acc = 0; inj_rd = 0;
    mb_left = pre_busy; rmode = rm;
    n_next = 0; n_rew = 0; seen_valid = 0;
    test_start_i = 1; start_cyc = cyc;
    @(posedge clk); #1;
    test_start_i = 0;

    waited = 0; viol = 0;
    while (!test_finished_o && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
      if (test_finished_o && (cmp_busy_i || meas_busy_i || trans_busy_i)) viol = 1;
      if (mid_start && waited == 3) test_start_i = 1;
      if (mid_start && waited == 4) test_start_i = 0;
    end
    test_start_i = 0;
    finish_cyc = cyc;
    if (!test_finished_o) begin
      n_cmp++; n_fail++;
      $display("FAIL finish_timeout: finished=0 after %0d cycles, expected 1 (mode %0d cnt %0d)", waited, mode, cnt);
      exp_q.delete();
      do_reset();
      return;
    end
    check("busy_after", test_busy_o, 0);
    check("result", test_result_o, (errs > 0 || mode > 3) ? 1 : 0);
    check("aborted", test_aborted_o, exp_ab);
    check("err_cnt", err_cnt_o, (errs > ERR_MAX) ? ERR_MAX : errs);
    check("cmds_left", exp_q.size(), 0);
    check("addr_next", n_next, exp_next);
    check("finish_vs_busy", viol, 0);
    if (n_ok > 0) check("first_valid", first_valid_cyc - start_cyc, 2);
    if (!ev) begin
      check("pass_cnt", pass_cnt_o, (mode > 3 || cnt == 0) ? 0 : eff);
      check("rewinds", n_rew, exp_rew);
      if (rm == 0 && pre_busy == 0)
        check("finish_latency", finish_cyc - start_cyc, 3 + n_ok + (exp_rew - 1));
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, trans_valid_o, 0);
    check({tag, "_type"}, trans_type_o, 0);
    check({tag, "_addr"}, trans_addr_o, 0);
    check({tag, "_next"}, addr_next_o, 0);
    check({tag, "_rewind"}, addr_rewind_o, 0);
    check({tag, "_busy"}, test_busy_o, 0);
    check({tag, "_finished"}, test_finished_o, 0);
    check({tag, "_result"}, test_result_o, 0);
    check({tag, "_aborted"}, test_aborted_o, 0);
    check({tag, "_err_cnt"}, err_cnt_o, 0);
    check({tag, "_pass_cnt"}, pass_cnt_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1; test_start_i = 0;
    test_mode_i = '0; test_count_i = '0; test_repeat_i = '0; stop_on_err_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1 rst_i = 0;

    run_test(0, 4, 1, 0, 64'h0, 0, 0, 0, 0);             // write-only, full rate
    run_test(2, 3, 1, 0, 64'h0, 0, 0, 1, 0);             // write+check, ready toggling
    run_test(3, 2, 2, 0, 64'h0, 0, 0, 0, 0);             // write-then-read, two passes
    run_test(0, 0, 1, 0, 64'h0, 0, 6, 0, 0);             // count 0, wait on meas busy
    run_test(5, 3, 1, 0, 64'h0, 0, 0, 0, 0);             // invalid mode
    run_test(1, 6, 1, 1, 64'h2, 0, 0, 0, 0);             // stop on 2nd read error
    run_test(1, 6, 1, 0, 64'h2A, 0, 0, 0, 0);            // continue, 3 errors
    run_test(0, 10, 1, 0, 64'h0, 4, 0, 0, 1);            // abort + ignored mid-test start
    run_test(1, 15, 2, 0, 64'h3FFFFFFF, 0, 0, 2, 0);     // error counter saturation
    run_test(1, 3, 0, 0, 64'h0, 0, 0, 0, 0);             // repeat 0 means one pass
    run_test(2, 2, 3, 0, 64'h0, 0, 0, 2, 0);             // word pairs across passes

    for (int t = 0; t < 25; t++) begin
      int m, c, r, ab, pb;
      bit s;
      logic [63:0] mk_mask;
      m  = ($urandom % 8 == 0) ? 5 : int'($urandom % 4);
      c  = int'($urandom % 7);
      r  = int'($urandom % 4);
      s  = 1'($urandom % 2);
      mk_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      ab = ($urandom % 4 == 0) ? int'(1 + $urandom % 8) : 0;
      pb = ($urandom % 2 == 0) ? int'($urandom % 4) : 0;
      run_test(m, c, r, s, mk_mask, ab, pb, int'($urandom % 3), 0);
    end

    // Reset in the middle of a running test
    @(posedge clk); #1;
    sb_off = 1; rmode = 0; err_mask = '0; abort_at = 0;
    base = ADDR_W'($urandom);
    test_mode_i = 3'd1; test_count_i = CNT_W'(15); test_repeat_i = REP_W'(1);
    stop_on_err_i = 0;
    test_start_i = 1;
    @(posedge clk); #1;
    test_start_i = 0;
    repeat (4) @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    @(negedge clk);
    check_idle_outputs("midreset");
    sb_off = 0;

    run_test(3, 3, 1, 0, 64'h4, 0, 0, 1, 0);             // sanity after mid-test reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
Parametrised test sequencer for the memory checker. It takes test parameters from the CSR block and issues a stream of write/read commands to the transmitter block over a valid/ready handshake. It drives the external address generator through next/rewind strobes. Compared with the single-pass controller, it adds a whole-pass write-then-read mode, pass repetition, an abort input, an optional continue-on-error mode, and error/pass counters.

Parameters:
ADDR_W, 31, transaction address width
CNT_W, 16, width of per-pass transaction count and error counter
REP_W, 8, width of repeat count and pass counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
test_start_i  in  1  start pulse; honoured only in IDLE
test_abort_i  in  1  abort request
test_mode_i  in  3  0 WRITE_ONLY, 1 READ_ONLY, 2 WRITE_AND_CHECK, 3 WRITE_THEN_READ
test_count_i  in  CNT_W  transactions (or word pairs) per pass
test_repeat_i  in  REP_W  number of passes; 0 is treated as 1
stop_on_err_i  in  1  1: first error ends the test
cmp_error_i  in  1  compare mismatch pulse
cmp_busy_i  in  1  compare block busy
meas_busy_i  in  1  measure block busy
trans_busy_i  in  1  transmitter busy
trans_ready_i  in  1  transmitter accepts command
trans_valid_o  out  1  command valid
trans_type_o  out  1  0 write, 1 read
trans_addr_o  out  ADDR_W  command address, equal to addr_i
addr_i  in  ADDR_W  current address from address generator
addr_next_o  out  1  advance address generator (one-cycle pulse)
addr_rewind_o  out  1  reload start address (one-cycle pulse)
test_busy_o  out  1  high in any state except IDLE
test_finished_o  out  1  sticky done flag
test_result_o  out  1  sticky error flag
test_aborted_o  out  1  sticky abort flag
err_cnt_o  out  CNT_W  saturating error count
pass_cnt_o  out  REP_W  completed passes

Behaviour:
- Reset: state IDLE, counters 0. All outputs are 0.
- Accept = trans_valid_o & trans_ready_i.
  - trans_valid_o, trans_type_o and trans_addr_o are decoded from registered state.
  - While valid is high and not accepted, type and addr hold stable.
  - Maximum rate is one accept per cycle.
- The address generator updates addr_i on the clock edge after addr_next_o or addr_rewind_o.
- States:
  - IDLE: on test_start_i, go to LOAD. In the same cycle, clear the finished/result/aborted flags and both counters.
  - LOAD: latch mode, count and repeat. Pulse addr_rewind_o. Loaded remaining-count = count.
    - count==0 or mode>3: go to DRAIN. For mode>3, also set test_result_o.
    - Otherwise go to the mode's first issue state. First valid appears 2 cycles after start is sampled.
  - WR_PASS (type 0) / RD_PASS (type 1):
    - Each accept pulses addr_next_o and decrements remaining.
    - The accept that takes remaining from 1 to 0 ends the pass.
  - WR_WORD (type 0): on accept go to RD_WORD. No address advance.
  - RD_WORD (type 1): on accept pulse addr_next_o and decrement. Go to WR_WORD, or end the pass on the last pair.
  - REWIND: one cycle. Pulse addr_rewind_o and reload remaining = count. Then go to the next issue state.
  - DRAIN: trans_valid_o=0. When cmp_busy_i, meas_busy_i and trans_busy_i are all 0: set test_finished_o and go to IDLE.
- Pass sequencing:
  - WRITE_THEN_READ: WR_PASS end, then REWIND, then RD_PASS.
  - End of pass: pass_cnt_o increments (wraps at 2^REP_W). If passes remain, go to REWIND then the mode's first state; else go to DRAIN.
- Errors (counted only while test_busy_o, DRAIN included): set test_result_o; err_cnt_o saturates at all-ones.
  - stop_on_err_i=1: the next state is DRAIN, regardless of any same-cycle accept. An unaccepted command is dropped.
- Abort: test_abort_i in any non-IDLE, non-DRAIN state goes to DRAIN and sets test_aborted_o. Abort in IDLE is ignored.
- test_start_i outside IDLE is ignored.
- Mid-test rst_i returns everything to reset values on the next edge.

Test Plan:
- WRITE_ONLY, count=4, repeat=1, ready always 1 -> 4 writes on consecutive cycles; first valid 2 cycles after start. addr_next_o pulses 4 times, pass_cnt_o=1, finished=1, result=0.
- WRITE_AND_CHECK, count=3, ready toggling 1/0 -> sequence W,R,W,R,W,R with each W/R pair on the same address. addr_next_o only after reads; addr/type stable while stalled.
- WRITE_THEN_READ, count=2, repeat=2 -> W,W, rewind, R,R, rewind, W,W, rewind, R,R. addr_rewind_o pulses 4 times, pass_cnt_o=2.
- count=0 -> no trans_valid_o; finished after busies clear. mode=5 -> finished=1, result=1.
- stop_on_err=1, error on 2nd of 6 reads -> valid drops next cycle; finished waits for cmp_busy_i low; err_cnt_o=1. stop_on_err=0 with 3 errors -> all 6 reads issued, err_cnt_o=3.
- test_abort_i mid-pass with trans_busy_i high for 5 cycles -> valid drops next cycle, finished asserts after busy clears, aborted=1. Start pulse during the test is ignored.
